shift_deserializer: RTL
=======================

Name: shift_deserializer

Overview:
- Receive end of the 2-bit shifter datapath: collects a stream of 2-bit symbols and reassembles them into WIDTH-bit words.
- Input and output both use valid/ready handshakes.
- Sits downstream of the shifter/serializer stage and feeds word-wide consumers.
- Provides full-rate throughput with a single-entry output holding slot and backpressure to the symbol source.

Parameters:
- WIDTH, 8, output word width in bits; must be even and >= 4; N = WIDTH/2 symbols per word.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear: discards the partial word; does not affect the holding slot.
- in_data  input  2  symbol, first symbol = most-significant 2 bits.
- in_valid  input  1  symbol present.
- in_ready  output  1  symbol accepted when in_valid & in_ready.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  word present in holding slot.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_perr  output  1  parity error flag for the current out_data (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - acc=0, cnt=0, state=S_COLLECT.
  - out_valid=0, out_data=0, out_perr=0.
  - in_ready reflects the reset state, i.e. it is 1.
- Symbol accept: acc <= {acc[WIDTH-3:0], in_data}; cnt increments.
- Word completion:
  - On the accepted symbol with cnt==N-1 (feature off), cnt wraps to 0.
  - Full word {acc[WIDTH-3:0], in_data} loads into out_data; out_valid=1 on the next cycle.
  - Latency: last symbol accepted at cycle T -> out_valid high at T+1.
- in_ready = !(completing symbol pending) || !out_valid || out_ready.
  - A word-completing symbol is accepted only if the slot is empty or drains the same cycle.
  - Non-completing symbols are always accepted.
- Simultaneous drain and completion: old word leaves, new word loads, out_valid stays 1. No bubble; sustained one symbol/cycle.
- Drain only: out_valid -> 0 next cycle; out_data holds its last value.
- out_valid & !out_ready: out_data and out_perr are stable until accepted.
- clr:
  - Sets cnt=0 and state=S_COLLECT; in_data is ignored that cycle.
  - clr has priority over a simultaneous symbol accept.
  - The holding slot is untouched.
- in_valid low mid-word: partial word is retained indefinitely; no timeout.
- Reset mid-word or with a word held: everything is discarded.
- States:
  - S_COLLECT: counts data symbols.
  - S_PARITY: feature only; expects the parity symbol.
  - Without the feature, S_COLLECT only and cnt wraps N-1 -> 0.

Optional Feature:
- Macro: SHIFT_DESER_PARITY_EN.
- Defined:
  - Each frame is N data symbols followed by one parity symbol.
  - Expected parity = XOR of the N data symbols (2-bit).
  - At cnt==N-1, the state goes to S_PARITY instead of loading the slot.
  - The parity symbol is the word-completing symbol; the in_ready rule applies to it.
  - On acceptance: load out_data; out_perr = (in_data != running xor); return to S_COLLECT.
  - Running xor clears per frame and on clr.
- Undefined: no parity symbol; out_perr is tied to 0; the port still exists.

Decomposition:
- Package shift_pkg:
  - SYM_W=2.
  - typedef logic [SYM_W-1:0] sym_t.
  - typedef enum {S_COLLECT, S_PARITY} deser_state_t.
- One sub-module, shift_out_slot:
  - Single-entry valid/ready holding register for out_data/out_perr.
  - Exposes a "can_load" signal used in the in_ready equation.

Test Plan:
- Basic word, WIDTH=8: symbols 2'b10, 2'b11, 2'b00, 2'b01 back-to-back, out_ready=1 -> out_data=8'hB1, out_valid high exactly 1 cycle, 1 cycle after the 4th accept.
- Backpressure: out_ready=0, send two words (8'hB1 then 8'h5A) -> 4th symbol of word 2 stalls (in_ready=0); first 3 symbols are accepted. Raise out_ready -> B1 then 5A delivered in order, no loss.
- clr: 2 symbols of a word, then clr, then 4 symbols 2'b01, 2'b01, 2'b01, 2'b01 -> out_data=8'h55; pre-clr symbols absent.
- Async reset mid-word: 2 symbols, assert rst_n low between clock edges -> out_valid=0 and out_data=0 immediately. Next 4 symbols 2'b11 -> 8'hFF.
- Random stream: 8 random words with random in_valid/out_ready gaps -> scoreboard matches in order, and sustained throughput is 1 symbol/cycle when unstalled.
- SHIFT_DESER_PARITY_EN: 10, 11, 00, 01 + parity 00 -> 8'hB1 with out_perr=0. Same word with parity 01 -> out_perr=1.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types for the 2-bit shifter datapath: symbol width, symbol type and
// deserializer state encoding.
package shift_pkg;

  localparam int unsigned SYM_W = 2;

  typedef logic [SYM_W-1:0] sym_t;

  typedef enum logic {
    S_COLLECT,
    S_PARITY
  } deser_state_t;

endpackage

// File: rtl/shift_out_slot.sv
// Single-entry valid/ready holding register for an assembled word and its
// parity-error flag; can_load_o is high when a new word may be written this cycle.
module shift_out_slot #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             perr_o,
  output logic             can_load_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;
  logic             perr_q,  perr_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    perr_d  = perr_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      perr_d  = perr_i;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end

  assign valid_o    = valid_q;
  assign data_o     = data_q;
  assign perr_o     = perr_q;
  assign can_load_o = !valid_q || ready_i;

endmodule

// File: rtl/shift_deserializer.sv
// Reassembles a stream of 2-bit symbols (MSB symbol first) into WIDTH-bit words.
// Optional per-frame parity symbol enabled by defining SHIFT_DESER_PARITY_EN.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [SYM_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_perr
);

  localparam int unsigned N     = WIDTH / SYM_W;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);
`ifdef SHIFT_DESER_PARITY_EN
  localparam int unsigned ACC_W = WIDTH;
`else
  // Last data symbol goes straight into the slot, so only N-1 symbols are stored.
  localparam int unsigned ACC_W = WIDTH - SYM_W;
`endif

  deser_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [ACC_W-1:0] acc_q,   acc_d;
`ifdef SHIFT_DESER_PARITY_EN
  sym_t             xor_q,   xor_d;
`endif

  sym_t             sym;
  logic             completing;
  logic             accept;
  logic             can_load;
  logic             load;
  logic [WIDTH-1:0] load_data;
  logic             load_perr;

  assign sym = in_data;

`ifdef SHIFT_DESER_PARITY_EN
  assign completing = (state_q == S_PARITY);
`else
  assign completing = (cnt_q == LAST);
`endif

  assign in_ready = !completing || can_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    load      = 1'b0;
    load_perr = 1'b0;
`ifdef SHIFT_DESER_PARITY_EN
    xor_d     = xor_q;
    load_data = acc_q;
`else
    load_data = {acc_q, sym};
`endif
    if (clr) begin
      cnt_d   = '0;
      state_d = S_COLLECT;
`ifdef SHIFT_DESER_PARITY_EN
      xor_d   = '0;
`endif
    end else if (accept) begin
`ifdef SHIFT_DESER_PARITY_EN
      if (state_q == S_PARITY) begin
        load      = 1'b1;
        load_perr = (sym != xor_q);
        xor_d     = '0;
        state_d   = S_COLLECT;
      end else begin
        acc_d = ACC_W'({acc_q, sym});
        xor_d = xor_q ^ sym;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_PARITY;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`else
      acc_d = ACC_W'({acc_q, sym});
      if (completing) begin
        load  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_COLLECT;
      cnt_q   <= '0;
      acc_q   <= '0;
`ifdef SHIFT_DESER_PARITY_EN
      xor_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
`ifdef SHIFT_DESER_PARITY_EN
      xor_q   <= xor_d;
`endif
    end
  end

  shift_out_slot #(
    .WIDTH(WIDTH)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (load),
    .data_i    (load_data),
    .perr_i    (load_perr),
    .ready_i   (out_ready),
    .valid_o   (out_valid),
    .data_o    (out_data),
    .perr_o    (out_perr),
    .can_load_o(can_load)
  );

endmodule
